// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decoder feeding a registered output
// slot backed by a one-entry skid buffer, with flush and valid/ready flow.
module decode_stage #(
  parameter bit          SUPPORT_M     = 1'b1,
  parameter bit          SUPPORT_ZICSR = 1'b1,
  parameter int unsigned PC_WIDTH      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [4:0]          out_rd,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic                out_rd_write,
  output logic                out_rs1_read,
  output logic                out_rs2_read,
  output logic [31:0]         out_imm,
  output logic [4:0]          out_alu_op,
  output logic                out_op2_imm,
  output logic                out_op1_pc,
  output logic                out_op1_zero,
  output logic                out_op2_4,
  output logic                out_br,
  output logic                out_jal,
  output logic                out_jalr,
  output logic                out_mem_rd,
  output logic                out_mem_wr,
  output logic [2:0]          out_mem_op,
  output logic                out_csr_rd,
  output logic [1:0]          out_csr_op,
  output logic [11:0]         out_csr_addr,
  output logic                out_mret,
  output logic                out_wfi,
  output logic                out_ecall,
  output logic                out_ebreak,
  output logic                out_ill,
  output logic [31:0]         out_tval
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                rd_write;
    logic                rs1_read;
    logic                rs2_read;
    logic [31:0]         imm;
    logic [4:0]          alu_op;
    logic                op2_imm;
    logic                op1_pc;
    logic                op1_zero;
    logic                op2_4;
    logic                br;
    logic                jal;
    logic                jalr;
    logic                mem_rd;
    logic                mem_wr;
    logic [2:0]          mem_op;
    logic                csr_rd;
    logic [1:0]          csr_op;
    logic [11:0]         csr_addr;
    logic                mret;
    logic                wfi;
    logic                ecall;
    logic                ebreak;
    logic                ill;
    logic [31:0]         tval;
  } bundle_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr;

  assign opcode  = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign imm_u   = {in_instr[31:12], 12'b0};
  assign imm_j   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};
  assign imm_csr = {27'b0, in_instr[19:15]};

  bundle_t dec_raw, dec;
  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;

  // Combinational decode of the incoming instruction word.
  always_comb begin
    dec_raw          = '0;
    dec_raw.pc       = in_pc;
    dec_raw.rd       = in_instr[11:7];
    dec_raw.rs1      = in_instr[19:15];
    dec_raw.rs2      = in_instr[24:20];
    dec_raw.tval     = in_instr;
    dec_raw.csr_addr = '0;
    unique case (opcode)
      OpReg: begin
        dec_raw.rd_write = 1'b1;
        dec_raw.rs1_read = 1'b1;
        dec_raw.rs2_read = 1'b1;
        unique case (f7)
          7'b0000000: dec_raw.alu_op = {2'b00, f3};
          7'b0100000: begin
            if (f3 == 3'b000 || f3 == 3'b101) dec_raw.alu_op = {2'b01, f3};
            else                              dec_raw.ill    = 1'b1;
          end
          7'b0000001: begin
            if (SUPPORT_M) dec_raw.alu_op = {2'b10, f3};
            else           dec_raw.ill    = 1'b1;
          end
          default: dec_raw.ill = 1'b1;
        endcase
      end
      OpImm: begin
        dec_raw.rd_write = 1'b1;
        dec_raw.rs1_read = 1'b1;
        dec_raw.op2_imm  = 1'b1;
        dec_raw.imm      = imm_i;
        dec_raw.alu_op   = {2'b00, f3};
        if (f3 == 3'b001 && f7 != 7'b0000000) dec_raw.ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      dec_raw.alu_op[3] = 1'b1;
          else if (f7 != 7'b0000000) dec_raw.ill       = 1'b1;
        end
      end
      OpLoad: begin
        dec_raw.rd_write = 1'b1;
        dec_raw.rs1_read = 1'b1;
        dec_raw.op2_imm  = 1'b1;
        dec_raw.mem_rd   = 1'b1;
        dec_raw.mem_op   = f3;
        dec_raw.imm      = imm_i;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_raw.ill = 1'b1;
      end
      OpStore: begin
        dec_raw.rs1_read = 1'b1;
        dec_raw.rs2_read = 1'b1;
        dec_raw.op2_imm  = 1'b1;
        dec_raw.mem_wr   = 1'b1;
        dec_raw.mem_op   = f3;
        dec_raw.imm      = imm_s;
        if (f3[2] || f3 == 3'b011) dec_raw.ill = 1'b1;
      end
      OpBranch: begin
        dec_raw.rs1_read = 1'b1;
        dec_raw.rs2_read = 1'b1;
        dec_raw.br       = 1'b1;
        dec_raw.imm      = imm_b;
        dec_raw.alu_op   = {2'b00, f3};
        if (f3 == 3'b010 || f3 == 3'b011) dec_raw.ill = 1'b1;
      end
      OpLui: begin
        dec_raw.rd_write = 1'b1;
        dec_raw.op1_zero = 1'b1;
        dec_raw.op2_imm  = 1'b1;
        dec_raw.imm      = imm_u;
      end
      OpAuipc: begin
        dec_raw.rd_write = 1'b1;
        dec_raw.op1_pc   = 1'b1;
        dec_raw.op2_imm  = 1'b1;
        dec_raw.imm      = imm_u;
      end
      OpJal: begin
        dec_raw.rd_write = 1'b1;
        dec_raw.jal      = 1'b1;
        dec_raw.op1_pc   = 1'b1;
        dec_raw.op2_4    = 1'b1;
        dec_raw.imm      = imm_j;
      end
      OpJalr: begin
        dec_raw.rd_write = 1'b1;
        dec_raw.rs1_read = 1'b1;
        dec_raw.jalr     = 1'b1;
        dec_raw.op1_pc   = 1'b1;
        dec_raw.op2_4    = 1'b1;
        dec_raw.imm      = imm_i;
        if (f3 != 3'b000) dec_raw.ill = 1'b1;
      end
      OpMisc: begin
        // FENCE and FENCE.I retire as NOPs in this in-order pipe
        if (f3[2:1] != 2'b00) dec_raw.ill = 1'b1;
      end
      OpSystem: begin
        if (f3 == 3'b000) begin
          unique case (in_instr)
            32'h0000_0073: dec_raw.ecall  = 1'b1;
            32'h0010_0073: dec_raw.ebreak = 1'b1;
            32'h3020_0073: dec_raw.mret   = 1'b1;
            32'h1050_0073: dec_raw.wfi    = 1'b1;
            default:       dec_raw.ill    = 1'b1;
          endcase
        end else if (!SUPPORT_ZICSR || f3 == 3'b100) begin
          dec_raw.ill = 1'b1;
        end else begin
          dec_raw.csr_addr = in_instr[31:20];
          dec_raw.rs1_read = ~f3[2];
          dec_raw.op2_imm  = f3[2];
          dec_raw.imm      = f3[2] ? imm_csr : 32'h0;
          if (f3[1:0] == 2'b01) begin
            // CSRRW(I) to x0 must not trigger CSR read side effects
            dec_raw.csr_rd = (in_instr[11:7] != 5'd0);
            dec_raw.csr_op = 2'b01;
          end else begin
            dec_raw.csr_rd = 1'b1;
            dec_raw.csr_op = (in_instr[19:15] == 5'd0) ? 2'b00 : f3[1:0];
          end
          dec_raw.rd_write = dec_raw.csr_rd;
        end
      end
      default: dec_raw.ill = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) dec_raw.ill = 1'b1;
  end

  // Illegal instructions carry only their indices, PC and raw word.
  always_comb begin
    dec = dec_raw;
    if (dec_raw.ill) begin
      dec      = '0;
      dec.pc   = dec_raw.pc;
      dec.rd   = dec_raw.rd;
      dec.rs1  = dec_raw.rs1;
      dec.rs2  = dec_raw.rs2;
      dec.ill  = 1'b1;
      dec.tval = dec_raw.tval;
    end
  end

  logic out_free, in_fire;
  assign out_free = ~out_valid_q | out_ready;
  assign in_fire  = in_valid & ~skid_valid_q;

  // Output/skid slot steering; flush overrides every other event.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready     = ~skid_valid_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = out_q.pc;
  assign out_rd       = out_q.rd;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd_write = out_q.rd_write;
  assign out_rs1_read = out_q.rs1_read;
  assign out_rs2_read = out_q.rs2_read;
  assign out_imm      = out_q.imm;
  assign out_alu_op   = out_q.alu_op;
  assign out_op2_imm  = out_q.op2_imm;
  assign out_op1_pc   = out_q.op1_pc;
  assign out_op1_zero = out_q.op1_zero;
  assign out_op2_4    = out_q.op2_4;
  assign out_br       = out_q.br;
  assign out_jal      = out_q.jal;
  assign out_jalr     = out_q.jalr;
  assign out_mem_rd   = out_q.mem_rd;
  assign out_mem_wr   = out_q.mem_wr;
  assign out_mem_op   = out_q.mem_op;
  assign out_csr_rd   = out_q.csr_rd;
  assign out_csr_op   = out_q.csr_op;
  assign out_csr_addr = out_q.csr_addr;
  assign out_mret     = out_q.mret;
  assign out_wfi      = out_q.wfi;
  assign out_ecall    = out_q.ecall;
  assign out_ebreak   = out_q.ebreak;
  assign out_ill      = out_q.ill;
  assign out_tval     = out_q.tval;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus handshake,
// backpressure, flush and reset sequences.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2;
    logic        rd_write, rs1_read, rs2_read;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        op2_imm, op1_pc, op1_zero, op2_4, br, jal, jalr, mem_rd, mem_wr;
    logic [2:0]  mem_op;
    logic        csr_rd;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic        mret, wfi, ecall, ebreak, ill;
    logic [31:0] tval;
  } fld_t;

  typedef struct packed {
    logic [31:0] instr;
    fld_t        e;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid;
  logic [31:0] out_pc;
  fld_t got;

  // Second instance with the optional extensions removed.
  logic b_in_ready, b_out_valid;
  logic [31:0] b_out_pc, b_imm, b_tval;
  logic [4:0] b_rd, b_rs1, b_rs2, b_alu_op;
  logic b_rd_write, b_rs1_read, b_rs2_read, b_op2_imm, b_op1_pc, b_op1_zero, b_op2_4;
  logic b_br, b_jal, b_jalr, b_mem_rd, b_mem_wr, b_csr_rd, b_mret, b_wfi, b_ecall, b_ebreak;
  logic b_ill;
  logic [2:0] b_mem_op;
  logic [1:0] b_csr_op;
  logic [11:0] b_csr_addr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(got.rd), .out_rs1(got.rs1), .out_rs2(got.rs2),
    .out_rd_write(got.rd_write), .out_rs1_read(got.rs1_read), .out_rs2_read(got.rs2_read),
    .out_imm(got.imm), .out_alu_op(got.alu_op), .out_op2_imm(got.op2_imm),
    .out_op1_pc(got.op1_pc), .out_op1_zero(got.op1_zero), .out_op2_4(got.op2_4),
    .out_br(got.br), .out_jal(got.jal), .out_jalr(got.jalr), .out_mem_rd(got.mem_rd),
    .out_mem_wr(got.mem_wr), .out_mem_op(got.mem_op), .out_csr_rd(got.csr_rd),
    .out_csr_op(got.csr_op), .out_csr_addr(got.csr_addr), .out_mret(got.mret),
    .out_wfi(got.wfi), .out_ecall(got.ecall), .out_ebreak(got.ebreak), .out_ill(got.ill),
    .out_tval(got.tval)
  );

  decode_stage #(.SUPPORT_M(1'b0), .SUPPORT_ZICSR(1'b0), .PC_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_rd_write(b_rd_write), .out_rs1_read(b_rs1_read), .out_rs2_read(b_rs2_read),
    .out_imm(b_imm), .out_alu_op(b_alu_op), .out_op2_imm(b_op2_imm),
    .out_op1_pc(b_op1_pc), .out_op1_zero(b_op1_zero), .out_op2_4(b_op2_4),
    .out_br(b_br), .out_jal(b_jal), .out_jalr(b_jalr), .out_mem_rd(b_mem_rd),
    .out_mem_wr(b_mem_wr), .out_mem_op(b_mem_op), .out_csr_rd(b_csr_rd),
    .out_csr_op(b_csr_op), .out_csr_addr(b_csr_addr), .out_mret(b_mret),
    .out_wfi(b_wfi), .out_ecall(b_ecall), .out_ebreak(b_ebreak), .out_ill(b_ill),
    .out_tval(b_tval)
  );

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Raw register fields and tval come straight from the word; everything else zero.
  function automatic fld_t base(input logic [31:0] i);
    fld_t f;
    f      = '0;
    f.rd   = i[11:7];
    f.rs1  = i[19:15];
    f.rs2  = i[24:20];
    f.tval = i;
    return f;
  endfunction

  task automatic send(input logic [31:0] instr);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
  endtask

  vec_t tbl[$];
  fld_t e;

  initial begin
    // ---- vector table ----
    e = base(32'h002081B3); e.rd_write = 1; e.rs1_read = 1; e.rs2_read = 1;
    tbl.push_back('{e.tval, e});
    e = base(32'h027302B3); e.rd_write = 1; e.rs1_read = 1; e.rs2_read = 1;
    e.alu_op = 5'b10000; tbl.push_back('{e.tval, e});
    e = base(32'h40208133); e.rd_write = 1; e.rs1_read = 1; e.rs2_read = 1;
    e.alu_op = 5'b01000; tbl.push_back('{e.tval, e});
    e = base(32'hFE000EE3); e.br = 1; e.rs1_read = 1; e.rs2_read = 1;
    e.imm = 32'hFFFFFFFC; tbl.push_back('{e.tval, e});
    e = base(32'h008000EF); e.jal = 1; e.rd_write = 1; e.op1_pc = 1; e.op2_4 = 1;
    e.imm = 32'h8; tbl.push_back('{e.tval, e});
    e = base(32'h00000073); e.ecall = 1; tbl.push_back('{e.tval, e});
    e = base(32'h00100073); e.ebreak = 1; tbl.push_back('{e.tval, e});
    e = base(32'h30200073); e.mret = 1; tbl.push_back('{e.tval, e});
    e = base(32'h10500073); e.wfi = 1; tbl.push_back('{e.tval, e});
    e = base(32'hFFFFFFFF); e.ill = 1; tbl.push_back('{e.tval, e});
    e = base(32'h00000000); e.ill = 1; tbl.push_back('{e.tval, e});
    e = base(32'h40101093); e.ill = 1; tbl.push_back('{e.tval, e});
    e = base(32'h34001073); e.csr_op = 2'b01; e.csr_addr = 12'h340; e.rs1_read = 1;
    tbl.push_back('{e.tval, e});
    e = base(32'h3002E0F3); e.csr_rd = 1; e.rd_write = 1; e.csr_op = 2'b10;
    e.csr_addr = 12'h300; e.imm = 32'h5; e.op2_imm = 1; tbl.push_back('{e.tval, e});
    e = base(32'h300020F3); e.csr_rd = 1; e.rd_write = 1; e.csr_op = 2'b00;
    e.csr_addr = 12'h300; e.rs1_read = 1; tbl.push_back('{e.tval, e});
    e = base(32'hFFF00093); e.rd_write = 1; e.rs1_read = 1; e.op2_imm = 1;
    e.imm = 32'hFFFFFFFF; tbl.push_back('{e.tval, e});
    e = base(32'h4030D093); e.rd_write = 1; e.rs1_read = 1; e.op2_imm = 1;
    e.imm = 32'h403; e.alu_op = 5'b01101; tbl.push_back('{e.tval, e});
    e = base(32'h0080A283); e.rd_write = 1; e.rs1_read = 1; e.op2_imm = 1; e.mem_rd = 1;
    e.mem_op = 3'b010; e.imm = 32'h8; tbl.push_back('{e.tval, e});
    e = base(32'hFE20AE23); e.rs1_read = 1; e.rs2_read = 1; e.op2_imm = 1; e.mem_wr = 1;
    e.mem_op = 3'b010; e.imm = 32'hFFFFFFFC; tbl.push_back('{e.tval, e});
    e = base(32'h123451B7); e.rd_write = 1; e.op1_zero = 1; e.op2_imm = 1;
    e.imm = 32'h12345000; tbl.push_back('{e.tval, e});

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_fields", got, '0);
    chk("rst_pc", out_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table at full throughput ----
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = tbl[k].instr;
      in_pc    = 32'h1000 + 32'(4 * k);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", k), out_valid, 1'b1);
      chk($sformatf("vec%0d_fields", k), got, tbl[k].e);
      chk($sformatf("vec%0d_pc", k), out_pc, 32'h1000 + 32'(4 * k));
    end

    // ---- extensions disabled ----
    send(32'h027302B3);
    @(posedge clk); #1;
    chk("nom_ill", b_ill, 1'b1);
    chk("nom_rd_write", b_rd_write, 1'b0);
    chk("nom_tval", b_tval, 32'h027302B3);
    send(32'h300020F3);
    @(posedge clk); #1;
    chk("nozicsr_ill", b_ill, 1'b1);
    chk("nozicsr_csr_rd", b_csr_rd, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", out_valid, 1'b0);

    // ---- backpressure: A held, B in skid, C waits ----
    out_ready = 1'b0;
    send(32'h002081B3);
    send(32'h00308233);
    send(32'h004082B3);
    #1;
    chk("bp_hold_a", got.tval, 32'h002081B3);
    chk("bp_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("bp_stable_a", got.tval, 32'h002081B3);
    chk("bp_stable_valid", out_valid, 1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_out_b", got.tval, 32'h00308233);
    chk("bp_ready_again", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("bp_out_c", got.tval, 32'h004082B3);
    chk("bp_c_valid", out_valid, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_no_dup", out_valid, 1'b0);

    // ---- flush with only the output slot full and a new instruction offered ----
    out_ready = 1'b0;
    send(32'h002081B3);
    @(negedge clk);
    flush    = 1'b1;
    in_instr = 32'h00308233;
    @(posedge clk); #1;
    chk("fl1_valid", out_valid, 1'b0);
    chk("fl1_ready", in_ready, 1'b1);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fl1_dropped", out_valid, 1'b0);

    // ---- flush with both slots full ----
    out_ready = 1'b0;
    send(32'h002081B3);
    send(32'h00308233);
    @(negedge clk);
    chk("fl2_full", in_ready, 1'b0);
    flush    = 1'b1;
    in_instr = 32'h004082B3;
    @(posedge clk); #1;
    chk("fl2_valid", out_valid, 1'b0);
    chk("fl2_ready", in_ready, 1'b1);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fl2_dropped", out_valid, 1'b0);

    // ---- asynchronous reset mid-stream ----
    out_ready = 1'b0;
    send(32'h002081B3);
    send(32'h00308233);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_ready", in_ready, 1'b1);
    chk("ar_fields", got, '0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar_lost", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
